wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 163 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: three per-FU result FIFOs, round-robin granted onto one PRF write port and the CDB.
// Define WB_BYPASS_EN to let a result reach an empty queue's head in the cycle it arrives.
module wb_arbiter #(
  parameter int QDEPTH = 2,
  parameter int ROB_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             alu_valid,
  input  logic             b_valid,
  input  logic             mem_valid,
  output logic             alu_ready,
  output logic             b_ready,
  output logic             mem_ready,
  input  logic [6:0]       alu_pd,
  input  logic [6:0]       b_pd,
  input  logic [6:0]       mem_pd,
  input  logic [31:0]      alu_data,
  input  logic [31:0]      b_data,
  input  logic [31:0]      mem_data,
  input  logic [ROB_W-1:0] alu_rob,
  input  logic [ROB_W-1:0] b_rob,
  input  logic [ROB_W-1:0] mem_rob,
  output logic             prf_we,
  output logic [6:0]       prf_pd,
  output logic [31:0]      prf_data,
  output logic             cdb_valid,
  output logic [6:0]       cdb_pd,
  output logic [ROB_W-1:0] cdb_rob,
  output logic [2:0]       grant
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL    = CW'(QDEPTH);
  localparam logic [1:0]    IDX_MEM = 2'd2;

  typedef struct packed {
    logic [6:0]       pd;
    logic [31:0]      data;
    logic [ROB_W-1:0] rob;
  } entry_t;

  entry_t          q_mem    [3][QDEPTH];
  entry_t          in_entry [3];
  logic [PW-1:0]   rd_ptr   [3];
  logic [PW-1:0]   wr_ptr   [3];
  logic [CW-1:0]   count    [3];
  logic [1:0]      last_grant;
  logic [2:0]      in_valid, ready, req, push, pop, bypass;
  logic            any;
  logic [1:0]      win;
  entry_t          head;

  // Next candidate after base, walking ALU -> branch -> mem -> ALU.
  function automatic logic [1:0] rr_next(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  always_comb begin
    in_valid    = {mem_valid, b_valid, alu_valid};
    in_entry[0] = '{pd: alu_pd, data: alu_data, rob: alu_rob};
    in_entry[1] = '{pd: b_pd,   data: b_data,   rob: b_rob};
    in_entry[2] = '{pd: mem_pd, data: mem_data, rob: mem_rob};
  end

  // ready looks only at the registered count, so it never combinationally depends on valid.
  always_comb begin
    ready = '0;
    req   = '0;
    for (int i = 0; i < 3; i++) begin
      ready[i] = count[i] < FULL;
`ifdef WB_BYPASS_EN
      req[i]   = (count[i] != '0) || in_valid[i];
`else
      req[i]   = count[i] != '0;
`endif
    end
  end

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin : arb_p
    logic [1:0] cand;
    cand = '0;
    any  = 1'b0;
    win  = '0;
    for (int k = 1; k <= 3; k++) begin
      cand = rr_next(last_grant, 2'(k));
      if (!any && req[cand]) begin
        any = 1'b1;
        win = cand;
      end
    end
    if (flush || reset) any = 1'b0;
  end

  always_comb begin
    push   = '0;
    pop    = '0;
    bypass = '0;
    head   = '0;
    for (int i = 0; i < 3; i++) begin
      bypass[i] = any && (win == 2'(i)) && (count[i] == '0);
      pop[i]    = any && (win == 2'(i)) && (count[i] != '0);
      push[i]   = in_valid[i] && ready[i] && !flush && !bypass[i];
    end
    if (any) begin
`ifdef WB_BYPASS_EN
      head = (count[win] != '0) ? q_mem[win][rd_ptr[win]] : in_entry[win];
`else
      head = q_mem[win][rd_ptr[win]];
`endif
    end
  end

  assign alu_ready = ready[0];
  assign b_ready   = ready[1];
  assign mem_ready = ready[2];
  assign grant     = any ? (3'b001 << win) : 3'b000;
  assign cdb_valid = any;
  assign prf_we    = any && (head.pd != 7'd0);
  assign prf_pd    = head.pd;
  assign prf_data  = head.data;
  assign cdb_pd    = head.pd;
  assign cdb_rob   = head.rob;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= IDX_MEM;
      for (int i = 0; i < 3; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      if (any) last_grant <= win;
      for (int i = 0; i < 3; i++) begin
        if (flush) begin
          rd_ptr[i] <= '0;
          wr_ptr[i] <= '0;
          count[i]  <= '0;
        end else begin
          if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
          if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
          if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
          else if (!push[i] && pop[i]) count[i] <= count[i] - 1'b1;
        end
      end
    end
  end

  // NOTE: queue storage is not reset; counts and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (push[i]) q_mem[i][wr_ptr[i]] <= in_entry[i];
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter (default build, QDEPTH=2): latency, round-robin order,
// pd=0 completion, backpressure, flush and asynchronous reset.
module tb_wb_arbiter;
  localparam int ROB_W = 5;

  logic             clk = 1'b0;
  logic             reset, flush;
  logic             alu_valid, b_valid, mem_valid;
  logic             alu_ready, b_ready, mem_ready;
  logic [6:0]       alu_pd, b_pd, mem_pd;
  logic [31:0]      alu_data, b_data, mem_data;
  logic [ROB_W-1:0] alu_rob, b_rob, mem_rob;
  logic             prf_we, cdb_valid;
  logic [6:0]       prf_pd, cdb_pd;
  logic [31:0]      prf_data;
  logic [ROB_W-1:0] cdb_rob;
  logic [2:0]       grant;
  logic [2:0]       rdy;

  int vectors    = 0;
  int miscompares = 0;

  assign rdy = {mem_ready, b_ready, alu_ready};

  wb_arbiter #(.QDEPTH(2), .ROB_W(ROB_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alu_valid(alu_valid), .b_valid(b_valid), .mem_valid(mem_valid),
    .alu_ready(alu_ready), .b_ready(b_ready), .mem_ready(mem_ready),
    .alu_pd(alu_pd), .b_pd(b_pd), .mem_pd(mem_pd),
    .alu_data(alu_data), .b_data(b_data), .mem_data(mem_data),
    .alu_rob(alu_rob), .b_rob(b_rob), .mem_rob(mem_rob),
    .prf_we(prf_we), .prf_pd(prf_pd), .prf_data(prf_data),
    .cdb_valid(cdb_valid), .cdb_pd(cdb_pd), .cdb_rob(cdb_rob),
    .grant(grant)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0;
    alu_valid = 1'b0; b_valid = 1'b0; mem_valid = 1'b0;
    alu_pd = '0; b_pd = '0; mem_pd = '0;
    alu_data = '0; b_data = '0; mem_data = '0;
    alu_rob = '0; b_rob = '0; mem_rob = '0;
  endtask

  task automatic drive_all(input int c);
    alu_valid = 1'b1; alu_pd = 7'd10; alu_data = 32'hA000_0000 + 32'(c); alu_rob = ROB_W'(c);
    b_valid   = 1'b1; b_pd   = 7'd20; b_data   = 32'hB000_0000 + 32'(c); b_rob   = ROB_W'(c);
    mem_valid = 1'b1; mem_pd = 7'd30; mem_data = 32'hC000_0000 + 32'(c); mem_rob = ROB_W'(c);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    #2;
    vectors++;
    if ({prf_we, cdb_valid, grant, prf_pd, prf_data, cdb_pd, cdb_rob} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got we=%b cv=%b g=%b pd=%h data=%h rob=%h, expected all zero",
               prf_we, cdb_valid, grant, prf_pd, prf_data, cdb_rob);
    end
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (rdy !== 3'b111) begin
      miscompares++; $display("FAIL reset_ready: got %b expected 111", rdy);
    end
    vectors++;
    if ({grant, cdb_valid, prf_we} !== 5'b0) begin
      miscompares++; $display("FAIL reset_idle: got grant=%b cv=%b we=%b expected 0", grant, cdb_valid, prf_we);
    end
  endtask

  task automatic test_single();
    step();
    alu_valid = 1'b1; alu_pd = 7'd5; alu_data = 32'hDEAD_BEEF; alu_rob = 5'd3;
    @(negedge clk);
    vectors++;
    if ({grant, cdb_valid} !== 4'b0) begin
      miscompares++; $display("FAIL single_latency: got grant=%b cv=%b expected 0 before accept edge", grant, cdb_valid);
    end
    step();
    alu_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({grant, prf_we, cdb_valid} !== 5'b001_1_1) begin
      miscompares++; $display("FAIL single_grant: got grant=%b we=%b cv=%b expected 001 1 1", grant, prf_we, cdb_valid);
    end
    vectors++;
    if ({prf_pd, cdb_pd, prf_data, cdb_rob} !== {7'd5, 7'd5, 32'hDEAD_BEEF, 5'd3}) begin
      miscompares++; $display("FAIL single_payload: got pd=%0d cpd=%0d data=%h rob=%0d expected 5 5 deadbeef 3",
                              prf_pd, cdb_pd, prf_data, cdb_rob);
    end
    step();
    @(negedge clk);
    vectors++;
    if ({grant, cdb_valid, prf_data} !== '0) begin
      miscompares++; $display("FAIL single_dequeue: got grant=%b cv=%b data=%h expected 0", grant, cdb_valid, prf_data);
    end
  endtask

  task automatic test_pd_zero();
    step();
    mem_valid = 1'b1; mem_pd = 7'd0; mem_data = 32'h1234_5678; mem_rob = 5'd7;
    step();
    mem_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({grant, cdb_valid, prf_we} !== 5'b100_1_0) begin
      miscompares++; $display("FAIL pd0_ctrl: got grant=%b cv=%b we=%b expected 100 1 0", grant, cdb_valid, prf_we);
    end
    vectors++;
    if ({cdb_rob, cdb_pd, prf_data} !== {5'd7, 7'd0, 32'h1234_5678}) begin
      miscompares++; $display("FAIL pd0_payload: got rob=%0d pd=%0d data=%h expected 7 0 12345678", cdb_rob, cdb_pd, prf_data);
    end
  endtask

  // All three valid together and held for four cycles; queue depth 2 throttles acceptance.
  task automatic test_round_robin();
    logic [2:0]  eg [10];
    logic [31:0] ed [10];
    logic [2:0]  er [10];
    logic [6:0]  epd;
    eg = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b000};
    ed = '{32'h0, 32'hA000_0000, 32'hB000_0000, 32'hC000_0000, 32'hA000_0001,
           32'hB000_0001, 32'hC000_0001, 32'hA000_0002, 32'hB000_0003, 32'h0};
    er = '{3'b111, 3'b111, 3'b001, 3'b010, 3'b100, 3'b101, 3'b111, 3'b111, 3'b111, 3'b111};
    for (int c = 0; c < 10; c++) begin
      step();
      if (c < 4) drive_all(c);
      else idle_inputs();
      @(negedge clk);
      epd = (eg[c] == 3'b001) ? 7'd10 : (eg[c] == 3'b010) ? 7'd20 : (eg[c] == 3'b100) ? 7'd30 : 7'd0;
      vectors++;
      if (grant !== eg[c]) begin
        miscompares++; $display("FAIL rr_grant[%0d]: got %b expected %b", c, grant, eg[c]);
      end
      vectors++;
      if ({prf_data, prf_pd} !== {ed[c], epd}) begin
        miscompares++; $display("FAIL rr_data[%0d]: got %h/%0d expected %h/%0d", c, prf_data, prf_pd, ed[c], epd);
      end
      vectors++;
      if (rdy !== er[c]) begin
        miscompares++; $display("FAIL rr_ready[%0d]: got %b expected %b", c, rdy, er[c]);
      end
    end
  endtask

  // ALU offers three results; only two fit until one drains. Last grant was branch, so mem goes first.
  task automatic test_backpressure();
    logic [2:0]  eg [7];
    logic [31:0] ed [7];
    logic        ea [7];
    eg = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b001, 3'b001, 3'b000};
    ed = '{32'h0, 32'h3333_0000, 32'h1111_0000, 32'h2222_0000, 32'h1111_0001, 32'h1111_0002, 32'h0};
    ea = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 7; k++) begin
      step();
      idle_inputs();
      if (k <= 3) begin
        alu_valid = 1'b1; alu_pd = 7'd11; alu_data = 32'h1111_0000 + 32'((k < 3) ? k : 2);
      end
      if (k == 0) begin
        b_valid   = 1'b1; b_pd   = 7'd12; b_data   = 32'h2222_0000;
        mem_valid = 1'b1; mem_pd = 7'd13; mem_data = 32'h3333_0000;
      end
      @(negedge clk);
      vectors++;
      if ({grant, prf_data} !== {eg[k], ed[k]}) begin
        miscompares++; $display("FAIL bp_grant[%0d]: got %b/%h expected %b/%h", k, grant, prf_data, eg[k], ed[k]);
      end
      vectors++;
      if (alu_ready !== ea[k]) begin
        miscompares++; $display("FAIL bp_ready[%0d]: got %b expected %b", k, alu_ready, ea[k]);
      end
    end
  endtask

  task automatic test_flush();
    logic [2:0] eg [4];
    step();
    b_valid = 1'b1; b_pd = 7'd21; b_data = 32'h5555_0001;
    mem_valid = 1'b1; mem_pd = 7'd31; mem_data = 32'h5555_0002;
    step();
    idle_inputs();
    flush = 1'b1; alu_valid = 1'b1; alu_pd = 7'd9; alu_data = 32'h5555_0003;
    @(negedge clk);
    vectors++;
    if ({grant, cdb_valid, prf_we} !== 5'b0) begin
      miscompares++; $display("FAIL flush_cycle: got grant=%b cv=%b we=%b expected 0", grant, cdb_valid, prf_we);
    end
    step();
    idle_inputs();
    @(negedge clk);
    vectors++;
    if ({grant, cdb_valid, prf_we} !== 5'b0) begin
      miscompares++; $display("FAIL flush_after: got grant=%b cv=%b we=%b expected 0", grant, cdb_valid, prf_we);
    end
    vectors++;
    if (rdy !== 3'b111) begin
      miscompares++; $display("FAIL flush_ready: got %b expected 111", rdy);
    end
    // Last grant must still be ALU, so branch comes first on the refill.
    eg = '{3'b000, 3'b010, 3'b100, 3'b001};
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) drive_all(8);
      else idle_inputs();
      @(negedge clk);
      vectors++;
      if (grant !== eg[k]) begin
        miscompares++; $display("FAIL flush_refill[%0d]: got %b expected %b", k, grant, eg[k]);
      end
    end
    step();
    @(negedge clk);
    vectors++;
    if (cdb_valid !== 1'b0) begin
      miscompares++; $display("FAIL flush_drained: got cv=%b expected 0", cdb_valid);
    end
  endtask

  task automatic test_async_reset();
    logic [2:0] eg [4];
    step(); drive_all(20);
    step(); drive_all(21);
    @(negedge clk);
    vectors++;
    if (grant !== 3'b010) begin
      miscompares++; $display("FAIL ar_fill: got %b expected 010", grant);
    end
    step();
    idle_inputs();
    #1;
    vectors++;
    if (grant !== 3'b100) begin
      miscompares++; $display("FAIL ar_pre: got %b expected 100", grant);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({prf_we, cdb_valid, grant, prf_pd, prf_data, cdb_pd, cdb_rob} !== '0) begin
      miscompares++; $display("FAIL ar_immediate: got we=%b cv=%b g=%b pd=%h data=%h expected all zero",
                              prf_we, cdb_valid, grant, prf_pd, prf_data);
    end
    @(posedge clk); #3;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({grant, cdb_valid, prf_we, rdy} !== 8'b000_0_0_111) begin
      miscompares++; $display("FAIL ar_release: got grant=%b cv=%b we=%b rdy=%b expected 000 0 0 111",
                              grant, cdb_valid, prf_we, rdy);
    end
    eg = '{3'b000, 3'b001, 3'b010, 3'b100};
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) drive_all(30);
      else idle_inputs();
      @(negedge clk);
      vectors++;
      if (grant !== eg[k]) begin
        miscompares++; $display("FAIL ar_order[%0d]: got %b expected %b", k, grant, eg[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_pd_zero();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
